// File: rtl/approx_add_pkg.sv
// Shared configuration and types for the approximate-adder arbiter slice.
package approx_add_pkg;

   localparam int NREQ       = 4;   // number of requesters (2..8)
   localparam int WIDTH      = 8;   // operand width
   localparam int LAT        = 1;   // adder latency, issue to add_sum valid (1..4)
   localparam int FIFO_DEPTH = 4;   // result FIFO entries (power of 2, >= LAT+1)

   localparam int ID_W  = $clog2(NREQ);
   localparam int SUM_W = WIDTH + 1;

   // Sideband carried alongside each op from issue to response.
   typedef struct packed {
      logic [ID_W-1:0] id;
      logic            approx;
   } tag_t;

   localparam int RESP_W = $bits(tag_t) + SUM_W;

   // One FIFO entry: tag plus the untouched adder result.
   typedef struct packed {
      tag_t             tag;
      logic [SUM_W-1:0] sum;
   } resp_t;

   // Round-robin successor of a requester index, wrapping mod NREQ.
   function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] idx);
      return (idx == ID_W'(NREQ - 1)) ? '0 : idx + ID_W'(1);
   endfunction

endpackage

// File: rtl/approx_add_arbiter_if.sv
// Bus bundle for the arbiter: requester side, adder side and response side.
interface approx_add_arbiter_if;
   import approx_add_pkg::*;

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_x;
   logic [NREQ*WIDTH-1:0] req_y;
   logic [NREQ-1:0]       req_cin;
   logic [NREQ-1:0]       req_approx;

   logic                  add_valid;
   logic [WIDTH-1:0]      add_x;
   logic [WIDTH-1:0]      add_y;
   logic                  add_cin;
   logic                  add_approx;
   logic [SUM_W-1:0]      add_sum;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [SUM_W-1:0]      rsp_sum;
   logic [ID_W-1:0]       rsp_id;
   logic                  rsp_approx;

   // Arbiter view.
   modport slave (
      input  req_valid, req_x, req_y, req_cin, req_approx, add_sum, rsp_ready,
      output req_ready, add_valid, add_x, add_y, add_cin, add_approx,
             rsp_valid, rsp_sum, rsp_id, rsp_approx
   );

   // Environment view (requesters, adder, consumer).
   modport master (
      output req_valid, req_x, req_y, req_cin, req_approx, add_sum, rsp_ready,
      input  req_ready, add_valid, add_x, add_y, add_cin, add_approx,
             rsp_valid, rsp_sum, rsp_id, rsp_approx
   );

endinterface

// File: rtl/approx_add_rr_arb.sv
// Round-robin pick: first requester at or after ptr_i (wrapping) wins.
module approx_add_rr_arb
   import approx_add_pkg::*;
(
   input  logic [NREQ-1:0] req_i,
   input  logic [ID_W-1:0] ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [ID_W-1:0] idx_o,
   output logic            any_o
);

   // Scan NREQ candidates starting at the pointer; keep the first hit.
   always_comb begin
      int              cand;
      logic [ID_W-1:0] cand_idx;
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      grant_o  = '0;
      idx_o    = '0;
      any_o    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = int'(ptr_i) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         cand_idx = ID_W'(cand);
         if (!any_o && req_i[cand_idx]) begin
            any_o             = 1'b1;
            idx_o             = cand_idx;
            grant_o[cand_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/approx_add_arbiter.sv
// Shares one registered adder among NREQ requesters: round-robin issue under
// credit control, tag pipe matching adder latency, in-order result FIFO.
module approx_add_arbiter
   import approx_add_pkg::*;
(
   input logic                 clock,
   input logic                 reset_n,
   approx_add_arbiter_if.slave bus
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int IF_W  = $clog2(LAT + 1);
   localparam int CRD_W = $clog2(FIFO_DEPTH + LAT + 1);

   logic              en_q;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [WIDTH-1:0]  last_x_q, last_x_d, last_y_q, last_y_d;
   logic              last_cin_q, last_cin_d, last_approx_q, last_approx_d;

   logic [NREQ-1:0]   grant;
   logic [ID_W-1:0]   win_idx;
   logic              any_req;
   logic              credit_ok, issue_ok, hs;
   tag_t              tag_in;

   logic              tag_vld_q [LAT];
   tag_t              tag_q     [LAT];
   logic [IF_W-1:0]   inflight;

   logic [RESP_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              push, pop, rsp_vld;
   resp_t             head;

   approx_add_rr_arb u_arb (
      .req_i   (bus.req_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (grant),
      .idx_o   (win_idx),
      .any_o   (any_req)
   );

   // Count valid tag stages; these are the ops already holding a FIFO credit.
   always_comb begin
      inflight = '0;
      for (int s = 0; s < LAT; s++) inflight = inflight + IF_W'(tag_vld_q[s]);
   end

   // Credit uses registered counts only, so a pop frees space one cycle later.
   assign credit_ok = (CRD_W'(cnt_q) + CRD_W'(inflight)) < CRD_W'(FIFO_DEPTH);
   assign issue_ok  = reset_n && en_q && credit_ok;
   assign hs        = issue_ok && any_req;

   // Winner operands pass straight through on a handshake; otherwise hold the last issue.
   always_comb begin
      last_x_d      = last_x_q;
      last_y_d      = last_y_q;
      last_cin_d    = last_cin_q;
      last_approx_d = last_approx_q;
      rr_ptr_d      = rr_ptr_q;
      if (hs) begin
         last_x_d      = bus.req_x[win_idx*WIDTH +: WIDTH];
         last_y_d      = bus.req_y[win_idx*WIDTH +: WIDTH];
         last_cin_d    = bus.req_cin[win_idx];
         last_approx_d = bus.req_approx[win_idx];
         rr_ptr_d      = next_ptr(win_idx);
      end
   end

   assign tag_in         = {win_idx, last_approx_d};
   assign bus.req_ready  = issue_ok ? grant : '0;
   assign bus.add_valid  = hs;
   assign bus.add_x      = reset_n ? last_x_d : '0;
   assign bus.add_y      = reset_n ? last_y_d : '0;
   assign bus.add_cin    = reset_n && last_cin_d;
   assign bus.add_approx = reset_n && last_approx_d;

   assign push = reset_n && tag_vld_q[LAT-1];
   assign pop  = rsp_vld && bus.rsp_ready;

   // FIFO occupancy: simultaneous push and pop leaves the count unchanged.
   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
   end

   // Control state, tag pipe and FIFO pointers with synchronous reset.
   always_ff @(posedge clock) begin
      // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset_n) begin
         en_q          <= 1'b0;
         rr_ptr_q      <= '0;
         last_x_q      <= '0;
         last_y_q      <= '0;
         last_cin_q    <= 1'b0;
         last_approx_q <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         cnt_q         <= '0;
         for (int s = 0; s < LAT; s++) begin
            tag_vld_q[s] <= 1'b0;
            tag_q[s]     <= '0;
         end
      end else begin
         en_q          <= 1'b1;
         rr_ptr_q      <= rr_ptr_d;
         last_x_q      <= last_x_d;
         last_y_q      <= last_y_d;
         last_cin_q    <= last_cin_d;
         last_approx_q <= last_approx_d;
         tag_vld_q[0]  <= hs;
         tag_q[0]      <= tag_in;
         for (int s = 1; s < LAT; s++) begin
            tag_vld_q[s] <= tag_vld_q[s-1];
            tag_q[s]     <= tag_q[s-1];
         end
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         cnt_q <= cnt_d;
      end
   end

   // Result storage: adder sum captured with the tag leaving the last pipe stage.
   always_ff @(posedge clock) begin
      // NOTE: storage is not reset; empty-FIFO outputs are forced to zero instead.
      if (push) mem[wr_ptr_q] <= {tag_q[LAT-1], bus.add_sum};
   end

   assign rsp_vld        = reset_n && (cnt_q != '0);
   assign head           = resp_t'(mem[rd_ptr_q]);
   assign bus.rsp_valid  = rsp_vld;
   assign bus.rsp_sum    = rsp_vld ? head.sum : '0;
   assign bus.rsp_id     = rsp_vld ? head.tag.id : '0;
   assign bus.rsp_approx = rsp_vld && head.tag.approx;

   // Credit makes a push into a full FIFO impossible.
   a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
      !(push && !pop && cnt_q == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_approx_add_arbiter.sv
// Directed bench for approx_add_arbiter with an exact LAT-cycle adder stub.
module tb_approx_add_arbiter;
   import approx_add_pkg::*;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   total   = 0;
   int   bad     = 0;

   always #5 clock = ~clock;

   approx_add_arbiter_if bus ();

   approx_add_arbiter dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   // Exact adder stub: LAT register stages behind the issued operands.
   logic [SUM_W-1:0] stub_q [LAT];
   always @(posedge clock) begin
      stub_q[0] <= {1'b0, bus.add_x} + {1'b0, bus.add_y} + SUM_W'(bus.add_cin);
      for (int s = 1; s < LAT; s++) stub_q[s] <= stub_q[s-1];
   end
   assign bus.add_sum = stub_q[LAT-1];

   typedef struct {
      int               idx;
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      logic             cin;
      logic             approx;
      logic [SUM_W-1:0] sum;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic sample();
      @(negedge clock);
   endtask

   task automatic clear_reqs();
      bus.req_valid  = '0;
      bus.req_x      = '0;
      bus.req_y      = '0;
      bus.req_cin    = '0;
      bus.req_approx = '0;
   endtask

   task automatic set_req(input int i, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic cin, input logic approx);
      bus.req_x[i*WIDTH +: WIDTH] = x;
      bus.req_y[i*WIDTH +: WIDTH] = y;
      bus.req_cin[i]              = cin;
      bus.req_approx[i]           = approx;
      bus.req_valid[i]            = 1'b1;
   endtask

   function automatic logic [WIDTH-1:0] rr_x(input int i);
      return WIDTH'(8'h11 * (i + 1));
   endfunction

   function automatic logic [WIDTH-1:0] rr_y(input int i);
      return WIDTH'(8'h20 + i);
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int               exp_id  [16];
      logic [SUM_W-1:0] exp_sum [16];
      int               grants;

      vecs[0] = '{0, 8'h0F, 8'h01, 1'b0, 1'b0, 9'h010};
      vecs[1] = '{1, 8'hFF, 8'h01, 1'b0, 1'b0, 9'h100};
      vecs[2] = '{2, 8'h08, 8'h08, 1'b0, 1'b1, 9'h010};
      vecs[3] = '{3, 8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF};
      vecs[4] = '{0, 8'h80, 8'h80, 1'b1, 1'b1, 9'h101};
      vecs[5] = '{3, 8'h00, 8'h00, 1'b0, 1'b1, 9'h000};

      // Reset held three edges with every requester valid.
      clear_reqs();
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, rr_x(i), rr_y(i), i[0], i[1]);
      for (int c = 0; c < 3; c++) begin
         step();
         sample();
         check("rst_req_ready", bus.req_ready, 0);
         check("rst_add_valid", bus.add_valid, 0);
         check("rst_rsp_valid", bus.rsp_valid, 0);
         check("rst_add_x", bus.add_x, 0);
         check("rst_rsp_sum", bus.rsp_sum, 0);
      end
      reset_n = 1'b1;
      #1;
      check("post_rst_req_ready", bus.req_ready, 0);
      check("post_rst_add_valid", bus.add_valid, 0);

      // Round robin with all four requesting and the consumer always ready.
      for (int c = 0; c < 12; c++) begin
         step();
         sample();
         exp_id[c]  = c % NREQ;
         exp_sum[c] = {1'b0, rr_x(c % NREQ)} + {1'b0, rr_y(c % NREQ)} + SUM_W'((c % NREQ) & 1);
         check("rr_grant", bus.req_ready, NREQ'(1) << (c % NREQ));
         check("rr_add_valid", bus.add_valid, 1);
         check("rr_add_x", bus.add_x, rr_x(c % NREQ));
         if (c >= LAT + 1) begin
            check("rr_rsp_valid", bus.rsp_valid, 1);
            check("rr_rsp_id", bus.rsp_id, exp_id[c-LAT-1]);
            check("rr_rsp_sum", bus.rsp_sum, exp_sum[c-LAT-1]);
         end else begin
            check("rr_no_bypass", bus.rsp_valid, 0);
         end
      end
      for (int c = 12; c < 12 + LAT + 1; c++) begin
         step();
         clear_reqs();
         sample();
         check("rr_tail_add_valid", bus.add_valid, 0);
         check("rr_tail_rsp_id", bus.rsp_id, exp_id[c-LAT-1]);
         check("rr_tail_rsp_sum", bus.rsp_sum, exp_sum[c-LAT-1]);
      end
      step();
      sample();
      check("rr_drained", bus.rsp_valid, 0);

      // Single-op vectors: issue, latency, response fields.
      foreach (vecs[v]) begin
         step();
         clear_reqs();
         set_req(vecs[v].idx, vecs[v].x, vecs[v].y, vecs[v].cin, vecs[v].approx);
         sample();
         check("vec_grant", bus.req_ready, NREQ'(1) << vecs[v].idx);
         check("vec_add_valid", bus.add_valid, 1);
         check("vec_add_x", bus.add_x, vecs[v].x);
         check("vec_add_y", bus.add_y, vecs[v].y);
         check("vec_add_cin", bus.add_cin, vecs[v].cin);
         check("vec_add_approx", bus.add_approx, vecs[v].approx);
         check("vec_rsp_early", bus.rsp_valid, 0);
         for (int l = 1; l <= LAT; l++) begin
            step();
            clear_reqs();
            sample();
            check("vec_rsp_wait", bus.rsp_valid, 0);
         end
         step();
         sample();
         check("vec_rsp_valid", bus.rsp_valid, 1);
         check("vec_rsp_sum", bus.rsp_sum, vecs[v].sum);
         check("vec_rsp_id", bus.rsp_id, vecs[v].idx);
         check("vec_rsp_approx", bus.rsp_approx, vecs[v].approx);
         step();
         sample();
         check("vec_rsp_popped", bus.rsp_valid, 0);
      end

      // Backpressure: credit stops issue after FIFO_DEPTH grants.
      step();
      clear_reqs();
      bus.rsp_ready = 1'b0;
      set_req(1, 8'hFF, 8'h01, 1'b0, 1'b0);
      grants = 0;
      for (int c = 0; c < 8; c++) begin
         if (c != 0) step();
         sample();
         if (bus.req_ready == 4'b0010) grants++;
         check("bp_grant", bus.req_ready, (c < FIFO_DEPTH) ? 4'b0010 : 4'b0000);
      end
      check("bp_grant_count", grants, FIFO_DEPTH);
      for (int c = 0; c < 3; c++) begin
         step();
         sample();
         check("bp_hold_valid", bus.rsp_valid, 1);
         check("bp_hold_sum", bus.rsp_sum, 9'h100);
         check("bp_hold_id", bus.rsp_id, 1);
         check("bp_hold_ready", bus.req_ready, 0);
      end
      step();
      bus.rsp_ready = 1'b1;
      sample();
      check("bp_pop_cycle_ready", bus.req_ready, 0);
      check("bp_pop_cycle_valid", bus.rsp_valid, 1);
      step();
      sample();
      check("bp_resume_grant", bus.req_ready, 4'b0010);
      check("bp_resume_valid", bus.rsp_valid, 1);
      for (int d = 2; d <= 4; d++) begin
         step();
         if (d == 2) clear_reqs();
         sample();
         check("bp_drain_valid", bus.rsp_valid, 1);
         check("bp_drain_sum", bus.rsp_sum, 9'h100);
         check("bp_drain_ready", bus.req_ready, 0);
      end
      step();
      sample();
      check("bp_empty", bus.rsp_valid, 0);

      // Reset mid-flight: two ops issued, then one reset cycle.
      step();
      set_req(1, 8'h01, 8'h02, 1'b0, 1'b0);
      set_req(2, 8'h03, 8'h04, 1'b0, 1'b0);
      sample();
      check("mid_grant_a", bus.req_ready, 4'b0100);
      step();
      sample();
      check("mid_grant_b", bus.req_ready, 4'b0010);
      step();
      clear_reqs();
      reset_n = 1'b0;
      sample();
      check("mid_rst_rsp_valid", bus.rsp_valid, 0);
      check("mid_rst_add_x", bus.add_x, 0);
      step();
      reset_n = 1'b1;
      sample();
      check("mid_after_rsp_valid", bus.rsp_valid, 0);
      check("mid_after_add_x", bus.add_x, 0);
      for (int c = 0; c < 4; c++) begin
         step();
         sample();
         check("mid_discarded", bus.rsp_valid, 0);
      end
      step();
      set_req(1, 8'h3C, 8'h05, 1'b1, 1'b1);
      set_req(3, 8'h77, 8'h01, 1'b0, 1'b0);
      sample();
      check("mid_ptr_reset_grant", bus.req_ready, 4'b0010);
      check("mid_add_x", bus.add_x, 8'h3C);
      for (int l = 1; l <= LAT; l++) begin
         step();
         clear_reqs();
         sample();
         check("mid_rsp_wait", bus.rsp_valid, 0);
      end
      step();
      sample();
      check("mid_rsp_valid", bus.rsp_valid, 1);
      check("mid_rsp_sum", bus.rsp_sum, 9'h042);
      check("mid_rsp_id", bus.rsp_id, 1);
      check("mid_rsp_approx", bus.rsp_approx, 1);
      step();
      sample();
      check("mid_rsp_popped", bus.rsp_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
